add16_seq_ctrl: RTL and testbench

//  Sequencing stage wrapped around the combinational 16-bit gate-level adder DUT (add3).

---
 rtl/add16_pkg.sv | 18 +
 rtl/add16_op_fifo.sv | 63 ++++++
 rtl/add16_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_add16_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add16_pkg.sv
// Shared definitions for the 16-bit adder sequencing stage.
//   ADD_WIDTH : default operand/sum width of the gate-level adder
//   ST_*      : sequencer FSM state encodings
//   op_pair_t : one operand pair {a, b} as carried through the stage
package add16_pkg;

  localparam int unsigned ADD_WIDTH = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] a;
    logic [ADD_WIDTH-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/add16_op_fifo.sv
// Synchronous first-word-fall-through FIFO for operand pairs.
//   clk, rst        : clock, async active-high reset (empties the FIFO)
//   push_i, wdata_i : write request/data, ignored when full
//   pop_i, rdata_o  : read request, head-of-queue data (valid when !empty)
//   full_o, empty_o : registered occupancy flags
module add16_op_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Occupancy after this edge
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/add16_seq_ctrl.sv
// Sequencer around a combinational gate-level adder: buffers operand pairs,
// launches each onto the adder, waits SETTLE_CYCLES, captures and checks the
// sum against a+b, and hands the result downstream.
//   in_valid/in_ready/in_a/in_b        : operand stream (in_ready = !full)
//   add_a/add_b -> adder -> add_o      : registered launch, combinational return
//   out_valid/out_ready/out_sum/out_err: result stream, out_err flags mismatch
//   err_count                          : saturating mismatch count since reset
module add16_seq_ctrl
  import add16_pkg::*;
#(
  parameter int unsigned WIDTH         = ADD_WIDTH,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERRW          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_err,
  output logic [ERRW-1:0]  err_count
);

  localparam int unsigned CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [2*WIDTH-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic               pop_c, launch_c, mismatch_c;
  logic [WIDTH-1:0]   head_a, head_b;

  logic [1:0]         state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic               out_err_q, out_err_d;
  logic [ERRW-1:0]    err_count_q, err_count_d;

  add16_op_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i ({in_a, in_b}),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_a     = fifo_rdata[2*WIDTH-1:WIDTH];
  assign head_b     = fifo_rdata[WIDTH-1:0];
  assign mismatch_c = (add_o != ref_q);

  // Next-state, launch and capture logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    ref_d       = ref_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    launch_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) launch_c = 1'b1;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          out_sum_d   = add_o;
          out_err_d   = mismatch_c;
          out_valid_d = 1'b1;
          if (mismatch_c && (err_count_q != {ERRW{1'b1}}))
            err_count_d = err_count_q + 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) launch_c = 1'b1;
          else             state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Launch: pop head, drive adder, remember reference sum (carry dropped)
    if (launch_c) begin
      add_a_d = head_a;
      add_b_d = head_b;
      ref_d   = head_a + head_b;
      cnt_d   = CNTW'(SETTLE_CYCLES - 1);
      state_d = ST_SETTLE;
    end
  end

  assign pop_c = launch_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      ref_q       <= ref_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Bench for add16_seq_ctrl: behavioural adder (with a fault-injection
// override), a queue-based reference model, and directed plus random traffic.
module tb_add16_seq_ctrl;
  import add16_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [15:0] add_a, add_b, add_o;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic        out_err;
  logic [7:0]  err_count;

  logic        force_en;
  logic [15:0] force_val;

  always #5 clk = ~clk;

  // Behavioural adder, optionally overridden to provoke checker mismatches
  assign add_o = force_en ? force_val : 16'(add_a + add_b);

  add16_seq_ctrl #(
    .WIDTH(16), .DEPTH(4), .SETTLE_CYCLES(2), .ERRW(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err), .err_count(err_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  op_pair_t    model_q[$];
  int          res_cyc[$];
  logic [15:0] res_sum[$];
  logic        res_err[$];
  logic [7:0]  res_cnt[$];
  int          last_acc_cyc;
  int          model_errs;

  logic        stall_prev;
  logic [15:0] stall_sum;
  logic        stall_err;
  op_pair_t    mp;
  logic [15:0] exp_sum;
  logic        exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_res();
    res_cyc.delete(); res_sum.delete(); res_err.delete(); res_cnt.delete();
  endtask

  // Compare process: every result handshake checked against the queue model
  initial begin
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_sum", 32'(out_sum), 32'(stall_sum));
          check("hold_err", 32'(out_err), 32'(stall_err));
        end
        if (out_valid && out_ready) begin
          if (model_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL spurious_result: got sum %0h with no pending pair", out_sum);
          end else begin
            mp      = model_q.pop_front();
            exp_sum = force_en ? force_val : 16'(mp.a + mp.b);
            exp_err = (exp_sum != 16'(mp.a + mp.b));
            if (exp_err && model_errs < 255) model_errs++;
            check("model_sum", 32'(out_sum), 32'(exp_sum));
            check("model_err", 32'(out_err), 32'(exp_err));
            check("model_errcnt", 32'(err_count), 32'(model_errs));
            res_cyc.push_back(cyc);
            res_sum.push_back(out_sum);
            res_err.push_back(out_err);
            res_cnt.push_back(err_count);
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_sum  = out_sum;
        stall_err  = out_err;
        if (in_valid && in_ready) begin
          model_q.push_back('{a: in_a, b: in_b});
          last_acc_cyc = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and return just after the edge that accepts it
  task automatic push_wait(input logic [15:0] a, input logic [15:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL push_timeout: in_ready stayed 0 for pair %0h/%0h", a, b);
    end
    step();
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (model_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results still pending", model_q.size());
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    force_en = 1'b0; force_val = '0; model_errs = 0; last_acc_cyc = 0;
    repeat (2) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    rst = 1'b0;
    step();

    // T1 single op and latency
    clear_res(); out_ready = 1'b1;
    push_wait(16'h0003, 16'h0004);
    in_valid = 1'b0;
    drain(50);
    check("t1_count", 32'(res_sum.size()), 32'd1);
    if (res_sum.size() >= 1) begin
      check("t1_sum", 32'(res_sum[0]), 32'h0007);
      check("t1_err", 32'(res_err[0]), 32'd0);
      check("t1_latency", 32'(res_cyc[0] - last_acc_cyc), 32'd4);
    end

    // T2 wrap-around, carry discarded
    clear_res();
    push_wait(16'hFFFF, 16'h0001);
    push_wait(16'h8000, 16'h8000);
    in_valid = 1'b0;
    drain(50);
    check("t2_count", 32'(res_sum.size()), 32'd2);
    if (res_sum.size() >= 2) begin
      check("t2_sum0", 32'(res_sum[0]), 32'h0000);
      check("t2_sum1", 32'(res_sum[1]), 32'h0000);
      check("t2_err0", 32'(res_err[0]), 32'd0);
    end

    // T3 backpressure: 1 in flight + 4 buffered, then full
    clear_res(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_wait(16'(16'h0100 + i), 16'(16'h0010 * i));
    in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h1111;
    @(negedge clk);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    check("t3_no_extra_push", 32'(model_q.size()), 32'd5);
    check("t3_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    push_wait(16'hAAAA, 16'h1111);
    in_valid = 1'b0;
    drain(100);
    check("t3_count", 32'(res_sum.size()), 32'd6);
    if (res_sum.size() >= 6) begin
      for (int i = 0; i < 5; i++)
        check("t3_order", 32'(res_sum[i]), 32'(16'(16'h0100 + i + 16'h0010 * i)));
      check("t3_last", 32'(res_sum[5]), 32'hBBBB);
    end

    // T4 checker and err_count saturation
    clear_res(); force_en = 1'b1; force_val = 16'h1234;
    push_wait(16'h0001, 16'h0001);
    in_valid = 1'b0;
    drain(50);
    if (res_err.size() >= 1) begin
      check("t4_err", 32'(res_err[0]), 32'd1);
      check("t4_cnt1", 32'(res_cnt[0]), 32'd1);
      check("t4_sum_forced", 32'(res_sum[0]), 32'h1234);
    end
    for (int i = 0; i < 255; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      if (16'(ra + rb) == 16'h1234) ra = ra ^ 16'h0001;
      push_wait(ra, rb);
    end
    in_valid = 1'b0;
    drain(2000);
    check("t4_sat_ff", 32'(err_count), 32'hFF);
    push_wait(16'h0002, 16'h0002);
    in_valid = 1'b0;
    drain(50);
    check("t4_sat_stays", 32'(err_count), 32'hFF);
    force_en = 1'b0;

    // T5 reset while a pair is settling
    push_wait(16'h0005, 16'h0006);
    in_valid = 1'b0;
    step();
    check("t5_launched_a", 32'(add_a), 32'h0005);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_ready", 32'(in_ready), 32'd1);
    check("t5_rst_errcnt", 32'(err_count), 32'd0);
    model_q.delete(); model_errs = 0;
    repeat (2) step();
    rst = 1'b0;
    clear_res();
    repeat (20) step();
    check("t5_no_stale", 32'(res_sum.size()), 32'd0);
    check("t5_idle_valid", 32'(out_valid), 32'd0);

    // T6 streaming: one result every 3 clocks
    clear_res(); out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_wait(16'($urandom), 16'($urandom));
    in_valid = 1'b0;
    drain(100);
    check("t6_count", 32'(res_sum.size()), 32'd8);
    if (res_cyc.size() >= 8) begin
      for (int i = 1; i < 8; i++) begin
        check("t6_spacing", 32'(res_cyc[i] - res_cyc[i-1]), 32'd3);
        check("t6_err", 32'(res_err[i]), 32'd0);
      end
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(200);
    check("rand_drained", 32'(model_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
